// File: rtl/operand_dispatch_control_pkg.sv
// Shared definitions for the operand dispatch controller: FSM states, sizing constants
// and the grouped push outputs.
package operand_dispatch_control_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned MAX_N    = 8;
    localparam int unsigned NUM_PROC = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLoadMat,
        StLoadVec,
        StStart,
        StWaitProc
    } state_e;

    typedef struct packed {
        logic [NUM_PROC-1:0] push_row;
        logic                push_vec;
    } dispatch_signals_t;

endpackage

// File: rtl/operand_dispatch_control_index_counter.sv
// Row/column index counter for the operand stream; column wraps at n-1 and carries into row.
module dispatch_index_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       row_en,
    input  logic [3:0] n,
    output logic [1:0] fifo_sel,
    output logic       col_last,
    output logic       row_last
);

    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;

    assign col_last = (col_q == n - 4'd1);
    assign row_last = (row_q == n - 4'd1);
    assign fifo_sel = row_q[1:0];

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = 4'd0;
            col_d = 4'd0;
        end else if (inc) begin
            if (col_last) begin
                col_d = 4'd0;
                // Row wraps too, so after the last matrix word both counters are back at 0
                if (row_en) row_d = row_last ? 4'd0 : row_q + 4'd1;
            end else begin
                col_d = col_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= 4'd0;
            col_q <= 4'd0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/operand_dispatch_control.sv
// Streams an N*N matrix then an N-vector into processor FIFOs and kicks off the computation.
module operand_dispatch_control #(
    parameter int unsigned DATA_W = operand_dispatch_control_pkg::DATA_W,
    parameter int unsigned MAX_N  = operand_dispatch_control_pkg::MAX_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [3:0]        cfg_N,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_ready,
    input  logic [3:0]        row_fifo_full,
    input  logic              vec_fifo_full,
    output logic [3:0]        push_row,
    output logic              push_vec,
    output logic [DATA_W-1:0] push_data,
    output logic              start_out,
    input  logic              proc_done,
    output logic              busy,
    output logic              cfg_err
);
    import operand_dispatch_control_pkg::*;

    state_e            state_q, state_d;
    logic [3:0]        n_q, n_d;
    logic              cfg_err_q, cfg_err_d;
    logic              start_q, busy_q;
    logic              cfg_ok, cfg_load;
    logic              xfer, mat_xfer, vec_xfer;
    logic [1:0]        fifo_sel;
    logic              col_last, row_last;
    dispatch_signals_t disp;

    assign cfg_ok   = (cfg_N != 4'd0) && (32'(cfg_N) <= MAX_N);
    assign cfg_load = (state_q == StIdle) && cfg_valid && cfg_ok;

    always_comb begin
        data_ready = 1'b0;
        if (!reset) begin
            case (state_q)
                StLoadMat: data_ready = ~row_fifo_full[fifo_sel];
                StLoadVec: data_ready = ~vec_fifo_full;
                default:   data_ready = 1'b0;
            endcase
        end
    end

    assign xfer     = data_valid && data_ready;
    assign mat_xfer = xfer && (state_q == StLoadMat);
    assign vec_xfer = xfer && (state_q == StLoadVec);

    always_comb begin
        disp          = '0;
        disp.push_row = mat_xfer ? (NUM_PROC'(1) << fifo_sel) : '0;
        disp.push_vec = vec_xfer;
    end

    assign push_row  = disp.push_row;
    assign push_vec  = disp.push_vec;
    assign push_data = data_in;
    assign start_out = start_q;
    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;

    dispatch_index_counter u_idx (
        .clk      (clk),
        .reset    (reset),
        .clr      (cfg_load),
        .inc      (mat_xfer || vec_xfer),
        .row_en   (state_q == StLoadMat),
        .n        (n_q),
        .fifo_sel (fifo_sel),
        .col_last (col_last),
        .row_last (row_last)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cfg_err_d = cfg_err_q;
        case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    if (cfg_ok) begin
                        n_d       = cfg_N;
                        cfg_err_d = 1'b0;
                        state_d   = StLoadMat;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StLoadMat:  if (mat_xfer && row_last && col_last) state_d = StLoadVec;
            StLoadVec:  if (vec_xfer && col_last) state_d = StStart;
            StStart:    state_d = StWaitProc;
            StWaitProc: if (proc_done) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // start/busy are registered off the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            n_q       <= 4'd0;
            cfg_err_q <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            cfg_err_q <= cfg_err_d;
            start_q   <= (state_d == StStart);
            busy_q    <= (state_d != StIdle);
        end
    end

endmodule
